// File: rtl/wshb_mire_if.sv
// rtl/wshb_mire_if.sv - Wishbone classic bus bundle between the mire generator and the interconnect
interface wshb_mire_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, dat_sm, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm, err, rty
    );
endinterface

// File: rtl/wshb_mire.sv
// rtl/wshb_mire.sv - grid test-pattern frame writer on Wishbone; WSHB_MIRE_ANIM_EN scrolls the vertical lines
module wshb_mire #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int GRID  = 16,
    parameter int BURST = 64
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    wshb_mire_if.master   wshb_ifm,
    output logic          frame_done
);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int IW = (HDISP * VDISP > 1) ? $clog2(HDISP * VDISP) : 1;
    localparam int GW = $clog2(GRID);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [0:0] {WRITE_REQ, PAUSE} state_t;

    state_t        state_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] burst_q;
    logic          stb_q;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, pat_d;
    logic [GW-1:0] off_d;
    logic [GW-1:0] vx_d;
    logic          acked;
    logic          last_x, last_y, wrap;

    assign acked  = stb_q & wshb_ifm.ack;
    assign last_x = (x_q == XW'(HDISP - 1));
    assign last_y = (y_q == YW'(VDISP - 1));
    assign wrap   = acked & last_x & last_y;

    // Counters advance only on an accepted write; the running index doubles as the word address.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        idx_d = idx_q;
        if (acked) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

`ifdef WSHB_MIRE_ANIM_EN
    logic [GW-1:0] off_q;
    assign off_d = off_q + GW'(wrap);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) off_q <= '0;
        else         off_q <= off_d;
    end
`else
    assign off_d = '0;
`endif

    // Pattern is evaluated for the pixel that will be presented next, including the new frame offset.
    assign vx_d  = x_d[GW-1:0] + off_d;
    assign pat_d = ((vx_d == '0) || (y_d[GW-1:0] == '0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    assign adr_d = 32'(idx_d) << 2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= WRITE_REQ;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            burst_q <= '0;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            idx_q <= idx_d;
            case (state_q)
                WRITE_REQ: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        adr_q <= adr_d;
                        dat_q <= pat_d;
                    end else if (wshb_ifm.ack) begin
                        if (burst_q == BW'(BURST - 1)) begin
                            burst_q <= '0;
                            stb_q   <= 1'b0;
                            state_q <= PAUSE;
                        end else begin
                            burst_q <= burst_q + 1'b1;
                            adr_q   <= adr_d;
                            dat_q   <= pat_d;
                        end
                    end
                end
                PAUSE: begin
                    state_q <= WRITE_REQ;
                    stb_q   <= 1'b1;
                    adr_q   <= adr_d;
                    dat_q   <= pat_d;
                end
                default: begin
                    state_q <= WRITE_REQ;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wshb_ifm.cyc    = stb_q;
    assign wshb_ifm.stb    = stb_q;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = adr_q;
    assign wshb_ifm.dat_ms = dat_q;
    assign frame_done      = wrap;

    logic unused_inputs;
    assign unused_inputs = ^{wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty};
endmodule

// File: tb/tb_wshb_mire.sv
// tb/tb_wshb_mire.sv - self-checking bench for wshb_mire against a pixel-sequence reference model
module tb_wshb_mire;
    localparam int HD   = 32;
    localparam int VD   = 8;
    localparam int GR   = 4;
    localparam int BU   = 8;
    localparam int NPIX = HD * VD;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic frame_done;

    wshb_mire_if bus ();

    wshb_mire #(.HDISP(HD), .VDISP(VD), .GRID(GR), .BURST(BU)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifm   (bus.master),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int p     = 0;
    int burst = 0;
    bit exp_pause = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_dat(input int pix);
        int x, y, off;
        x   = pix % HD;
        y   = (pix / HD) % VD;
        off = 0;
`ifdef WSHB_MIRE_ANIM_EN
        off = (pix / NPIX) % GR;
`endif
        return ((((x + off) % GR) == 0) || ((y % GR) == 0)) ? 32'h00FF_FFFF : 32'h0;
    endfunction

    // mode: 0 = ack at once, 1 = never ack, 2 = random ack
    task automatic step(input int mode);
        bit a;
        @(negedge sys_clk);
        if (exp_pause) begin
            check("pause_stb", {31'b0, bus.stb}, 32'd0);
            check("pause_cyc", {31'b0, bus.cyc}, 32'd0);
            bus.ack = 1'($urandom_range(0, 1));
            #1;
            check("pause_frame_done", {31'b0, frame_done}, 32'd0);
            exp_pause = 0;
        end else begin
            check("stb", {31'b0, bus.stb}, 32'd1);
            check("cyc", {31'b0, bus.cyc}, 32'd1);
            check("adr", bus.adr, 32'(4 * (p % NPIX)));
            check("dat", bus.dat_ms, model_dat(p));
            case (mode)
                0:       a = 1'b1;
                1:       a = 1'b0;
                default: a = ($urandom_range(0, 3) != 0);
            endcase
            bus.ack = a;
            #1;
            check("frame_done", {31'b0, frame_done}, {31'b0, a && ((p % NPIX) == NPIX - 1)});
            if (a) begin
                p++;
                burst++;
                if (burst == BU) begin
                    burst     = 0;
                    exp_pause = 1;
                end
            end
        end
    endtask

    task automatic run_to(input int target, input int mode);
        int n = 0;
        while (p < target && n < 5000) begin
            step(mode);
            n++;
        end
        check("run_to_bound", {31'b0, p >= target}, 32'd1);
    endtask

    initial begin
        bus.ack    = 1'b0;
        bus.dat_sm = 32'h0;
        bus.err    = 1'b0;
        bus.rty    = 1'b0;

        repeat (3) @(negedge sys_clk);
        check("rst_cyc", {31'b0, bus.cyc}, 32'd0);
        check("rst_stb", {31'b0, bus.stb}, 32'd0);
        check("rst_adr", bus.adr, 32'd0);
        check("rst_dat", bus.dat_ms, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        sys_rst = 1'b0;

        check("const_we", {31'b0, bus.we}, 32'd1);
        check("const_sel", {28'b0, bus.sel}, 32'hF);
        check("const_cti", {29'b0, bus.cti}, 32'd0);
        check("const_bte", {30'b0, bus.bte}, 32'd0);

        run_to(13, 0);
        repeat (5) step(1);
        run_to(40, 0);

        run_to(3 * NPIX + 20, 2);

        run_to((p / NPIX + 1) * NPIX + 3 * HD + 10, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        bus.ack = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_cyc", {31'b0, bus.cyc}, 32'd0);
        check("mid_rst_stb", {31'b0, bus.stb}, 32'd0);
        sys_rst   = 1'b0;
        p         = 0;
        burst     = 0;
        exp_pause = 0;
        run_to(20, 0);
        run_to(NPIX + 40, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
